sdcard_error_handler: RTL and testbench
=======================================

// Module: sdcard_error_handler
// PURPOSE
//  Parametrised multi-source error handler for the SD card controller. It collects NUM_SRC error
//  sources and services them one at a time in fixed priority order. Recoverable errors go through
//  a bounded retry handshake with the recovery engine; fatal errors are reported. Every handled error
//  is logged in a readable history FIFO. Sits between the cmd/data/DMA/power blocks and the APB regfile.
// PARAMETERS
//  NUM_SRC     8   number of error sources (1..16); index 0 = highest priority
//  HIST_DEPTH  8   history FIFO depth, power of 2, >=2
//  CNT_W       16  width of the error counter and the threshold
//  TS_W        16  width of the free-running timestamp
//  MAX_RETRY   3   retry attempts per event before escalating to report
// PORTS
//  PCLK_i            in   1               APB clock
//  PRESETn_i         in   1               reset, asynchronous, active-low
//  err_src_i         in   NUM_SRC         error level/pulse per source
//  cfg_enable_i      in   NUM_SRC         source enable; disabled sources are never latched
//  cfg_recov_i       in   NUM_SRC         1 = source is recoverable (retry), 0 = fatal
//  cfg_irq_en_i      in   1               global interrupt enable
//  cfg_threshold_i   in   CNT_W           error-count threshold; 0 disables it
//  retry_valid_o     out  1               retry request to the recovery engine
//  retry_src_o       out  $clog2(NUM_SRC) source being retried
//  retry_ready_i     in   1               recovery engine accepts the request
//  retry_done_i      in   1               one-cycle pulse: attempt finished
//  retry_ok_i        in   1               qualifies retry_done_i: attempt succeeded
//  err_clear_o       out  NUM_SRC         one-hot clear pulse to the serviced source
//  irq_o             out  1               error interrupt, level
//  irq_ack_i         in   1               interrupt acknowledge
//  hist_pop_i        in   1               pop the history head
//  hist_valid_o      out  1               history not empty
//  hist_data_o       out  see BEHAVIOUR   head entry
//  hist_ovf_o        out  1               sticky: an entry was dropped
//  err_count_o       out  CNT_W           saturating count of latched errors
//  thresh_hit_o      out  1               sticky: threshold reached
//  stat_clr_i        in   1               clears err_count_o, thresh_hit_o and hist_ovf_o
//  busy_o            out  1               state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; pend=0; FIFO empty; timestamp=0; state=IDLE.
//  - Reset mid-operation: retry_valid_o and irq_o drop asynchronously.
//  - pend[i] is set on err_src_i[i]&cfg_enable_i[i].
//    - Already-pending sources coalesce and are not counted again.
//    - err_count_o increments once per 0->1 pend transition, summed over sources in that cycle,
//      saturating at all-ones.
//  - thresh_hit_o is set when cfg_threshold_i!=0 && err_count_o>=cfg_threshold_i. It holds until
//    stat_clr_i; stat_clr_i wins over a same-cycle increment.
//  - Timestamp: free-running, wraps at 2^TS_W.
//  - FSM states: IDLE, SELECT, RETRY, WAIT, REPORT, LOG, CLEAR.
//    - IDLE->SELECT when pend!=0.
//    - SELECT latches act = lowest pending index, the timestamp, and retries=0.
//      Next state: RETRY if cfg_recov_i[act], else REPORT.
//    - RETRY: retry_valid_o=1 and retry_src_o=act, held stable until retry_ready_i. On handshake,
//      retries++ and go to WAIT.
//    - WAIT on retry_done_i: if retry_ok_i -> LOG (fatal=0). Else RETRY if retries<MAX_RETRY,
//      else REPORT.
//    - REPORT: set irq_o if cfg_irq_en_i; go to LOG with fatal=1.
//    - LOG pushes {fatal, act, retries[7:0], timestamp} (msb->lsb) into the FIFO.
//    - CLEAR: err_clear_o[act]=1 for one cycle; pend[act] is cleared unless err_src_i[act] is
//      asserted in the same cycle (set wins). Then go to IDLE.
//  - Latency for a fatal error with its first pend set on edge E (pend visible from E):
//    SELECT E+1, REPORT E+2, irq_o high from E+3, err_clear_o at E+4, back in IDLE at E+5.
//  - irq_o holds until irq_ack_i. A same-cycle set and ack leaves irq_o=1 (set wins).
//  - FIFO:
//    - Push when full and no pop: drop the new entry and set hist_ovf_o.
//    - Push and pop together when full: both happen, no overflow.
//    - Pop when empty: ignored.
//    - hist_data_o is don't-care when hist_valid_o=0.
//  - MAX_RETRY=0: a recoverable source goes SELECT->RETRY->WAIT and is never retried after a
//    failure, so a failed attempt escalates straight to REPORT.
// STRUCTURE
//  - sdcard_error_pkg holds: the state enum, and a clog2-safe width function for src index.
//  - sdcard_error_hist_fifo(WIDTH, DEPTH) is the sub-module: synchronous FIFO with full/empty/ovf.
//  - Priority encoder, pend register, FSM and counters live in the top module.
// TESTING
//  - Fatal path: cfg_recov_i=0, pulse src3 -> irq_o at E+3, err_clear_o=8'h08 at E+4,
//    hist_data_o={1,3,0,ts}.
//  - Retry success: src1 recoverable, retry_ok_i=1 on first done -> no irq, one log entry
//    {0,1,1,ts}.
//  - Retry exhaustion: MAX_RETRY=3, all attempts fail -> exactly 3 retry handshakes, then irq,
//    entry retries=3.
//  - Priority and coalescing: src5 and src2 in the same cycle -> src2 serviced first.
//    Re-pulsing src5 while it is pending -> err_count_o rises by 2 only.
//  - FIFO: 9 fatal events with no pop -> hist_ovf_o=1 and 8 entries. Push with simultaneous pop
//    when full -> ovf stays 0.
//  - Threshold and reset: threshold=2, 2 errors -> thresh_hit_o=1, cleared by stat_clr_i.
//    PRESETn_i during RETRY -> retry_valid_o drops at once, state IDLE.

Source files
------------

// File: rtl/sdcard_error_pkg.sv
// Shared types for the SD card error handler: FSM state encoding and the
// source-index width helper.
package sdcard_error_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_RETRY,
        ST_WAIT,
        ST_REPORT,
        ST_LOG,
        ST_CLEAR
    } state_e;

    // A single source still needs a 1-bit index field.
    function automatic int src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sdcard_error_hist_fifo.sv
// Synchronous history FIFO with a sticky overflow flag. It drops new entries
// when full unless a pop frees a slot in the same cycle.
module sdcard_error_hist_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 8
) (
    input  logic             PCLK_i,
    input  logic             PRESETn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             ovf_q, ovf_d;
    logic             empty, full, do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        ovf_d = ovf_q | (push_i && full && !pop_i);
        if (ovf_clr_i) ovf_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            ovf_q <= ovf_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge PCLK_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign valid_o = !empty;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/sdcard_error_handler.sv
// Multi-source error handler: latches enabled error sources, services them in
// fixed priority with bounded retries, reports fatal errors and logs every event.
module sdcard_error_handler
    import sdcard_error_pkg::*;
#(
    parameter int NUM_SRC    = 8,
    parameter int HIST_DEPTH = 8,
    parameter int CNT_W      = 16,
    parameter int TS_W       = 16,
    parameter int MAX_RETRY  = 3
) (
    input  logic                          PCLK_i,
    input  logic                          PRESETn_i,
    input  logic [NUM_SRC-1:0]            err_src_i,
    input  logic [NUM_SRC-1:0]            cfg_enable_i,
    input  logic [NUM_SRC-1:0]            cfg_recov_i,
    input  logic                          cfg_irq_en_i,
    input  logic [CNT_W-1:0]              cfg_threshold_i,
    output logic                          retry_valid_o,
    output logic [src_w(NUM_SRC)-1:0]     retry_src_o,
    input  logic                          retry_ready_i,
    input  logic                          retry_done_i,
    input  logic                          retry_ok_i,
    output logic [NUM_SRC-1:0]            err_clear_o,
    output logic                          irq_o,
    input  logic                          irq_ack_i,
    input  logic                          hist_pop_i,
    output logic                          hist_valid_o,
    output logic [src_w(NUM_SRC)+TS_W+8:0] hist_data_o,
    output logic                          hist_ovf_o,
    output logic [CNT_W-1:0]              err_count_o,
    output logic                          thresh_hit_o,
    input  logic                          stat_clr_i,
    output logic                          busy_o
);
    localparam int SRC_W  = src_w(NUM_SRC);
    localparam int HIST_W = 1 + SRC_W + 8 + TS_W;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d, set_vec, rise_vec;
    logic [SRC_W-1:0]   act_q, act_d, prio_idx;
    logic [7:0]         retries_q, retries_d;
    logic               fatal_q, fatal_d;
    logic [TS_W-1:0]    ts_q, ts_lat_q, ts_lat_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W:0]     count_sum;
    logic [4:0]         inc;
    logic               thresh_q, thresh_d, irq_q, irq_d, log_push;

    always_comb begin
        prio_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pend_q[i]) prio_idx = SRC_W'(i);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        act_d         = act_q;
        ts_lat_d      = ts_lat_q;
        retries_d     = retries_q;
        fatal_d       = fatal_q;
        retry_valid_o = 1'b0;
        err_clear_o   = '0;
        log_push      = 1'b0;
        case (state_q)
            ST_IDLE: if (|pend_q) state_d = ST_SELECT;
            ST_SELECT: begin
                act_d     = prio_idx;
                ts_lat_d  = ts_q;
                retries_d = '0;
                fatal_d   = 1'b0;
                state_d   = cfg_recov_i[prio_idx] ? ST_RETRY : ST_REPORT;
            end
            ST_RETRY: begin
                retry_valid_o = 1'b1;
                if (retry_ready_i) begin
                    retries_d = retries_q + 8'd1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (retry_done_i) begin
                    if (retry_ok_i) begin
                        fatal_d = 1'b0;
                        state_d = ST_LOG;
                    end else if (retries_q < 8'(MAX_RETRY)) begin
                        state_d = ST_RETRY;
                    end else begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                fatal_d = 1'b1;
                state_d = ST_LOG;
            end
            ST_LOG: begin
                log_push = 1'b1;
                state_d  = ST_CLEAR;
            end
            ST_CLEAR: begin
                err_clear_o[act_q] = 1'b1;
                state_d            = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A source re-asserting during its own clear keeps pend set (set wins).
    always_comb begin
        set_vec  = err_src_i & cfg_enable_i;
        rise_vec = set_vec & ~pend_q;
        pend_d   = (pend_q & ~err_clear_o) | set_vec;
        inc      = '0;
        for (int i = 0; i < NUM_SRC; i++) inc = inc + 5'(rise_vec[i]);
        count_sum = {1'b0, count_q} + (CNT_W+1)'(inc);
        if (stat_clr_i)             count_d = '0;
        else if (count_sum[CNT_W])  count_d = '1;
        else                        count_d = count_sum[CNT_W-1:0];
        thresh_d = thresh_q | ((cfg_threshold_i != '0) && (count_q >= cfg_threshold_i));
        if (stat_clr_i) thresh_d = 1'b0;
        irq_d = irq_q;
        if (irq_ack_i) irq_d = 1'b0;
        if (state_q == ST_REPORT && cfg_irq_en_i) irq_d = 1'b1;
    end

    always_ff @(posedge PCLK_i or negedge PRESETn_i) begin
        if (!PRESETn_i) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            act_q     <= '0;
            retries_q <= '0;
            fatal_q   <= 1'b0;
            ts_q      <= '0;
            ts_lat_q  <= '0;
            count_q   <= '0;
            thresh_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            retries_q <= retries_d;
            fatal_q   <= fatal_d;
            ts_q      <= ts_q + 1'b1;
            ts_lat_q  <= ts_lat_d;
            count_q   <= count_d;
            thresh_q  <= thresh_d;
            irq_q     <= irq_d;
        end
    end

    sdcard_error_hist_fifo #(
        .WIDTH (HIST_W),
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .PCLK_i    (PCLK_i),
        .PRESETn_i (PRESETn_i),
        .push_i    (log_push),
        .data_i    ({fatal_q, act_q, retries_q, ts_lat_q}),
        .pop_i     (hist_pop_i),
        .ovf_clr_i (stat_clr_i),
        .data_o    (hist_data_o),
        .valid_o   (hist_valid_o),
        .ovf_o     (hist_ovf_o)
    );

    assign retry_src_o  = act_q;
    assign irq_o        = irq_q;
    assign err_count_o  = count_q;
    assign thresh_hit_o = thresh_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdcard_error_handler.sv
// Scoreboard bench for sdcard_error_handler: stimulus queues expected clears,
// retry requests and history entries; monitors pop and compare them.
module tb_sdcard_error_handler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  err_src_i, cfg_enable_i, cfg_recov_i;
    logic        cfg_irq_en_i;
    logic [15:0] cfg_threshold_i;
    logic        retry_valid_o;
    logic [2:0]  retry_src_o;
    logic        retry_ready_i, retry_done_i, retry_ok_i;
    logic [7:0]  err_clear_o;
    logic        irq_o, irq_ack_i, hist_pop_i, hist_valid_o, hist_ovf_o;
    logic [27:0] hist_data_o;
    logic [15:0] err_count_o;
    logic        thresh_hit_o, stat_clr_i, busy_o;

    int vectors = 0;
    int miscompares = 0;

    logic [27:0] exp_hist_q[$];
    logic [7:0]  exp_clr_q[$];
    logic [2:0]  exp_retry_q[$];
    bit          ok_q[$];
    logic [15:0] ts_model;
    int          eng_wait = 0;
    bit          eng_hold = 0;

    always #5 clk = ~clk;

    sdcard_error_handler dut (
        .PCLK_i          (clk),
        .PRESETn_i       (rst_n),
        .err_src_i       (err_src_i),
        .cfg_enable_i    (cfg_enable_i),
        .cfg_recov_i     (cfg_recov_i),
        .cfg_irq_en_i    (cfg_irq_en_i),
        .cfg_threshold_i (cfg_threshold_i),
        .retry_valid_o   (retry_valid_o),
        .retry_src_o     (retry_src_o),
        .retry_ready_i   (retry_ready_i),
        .retry_done_i    (retry_done_i),
        .retry_ok_i      (retry_ok_i),
        .err_clear_o     (err_clear_o),
        .irq_o           (irq_o),
        .irq_ack_i       (irq_ack_i),
        .hist_pop_i      (hist_pop_i),
        .hist_valid_o    (hist_valid_o),
        .hist_data_o     (hist_data_o),
        .hist_ovf_o      (hist_ovf_o),
        .err_count_o     (err_count_o),
        .thresh_hit_o    (thresh_hit_o),
        .stat_clr_i      (stat_clr_i),
        .busy_o          (busy_o)
    );

    // Free-running timestamp reference.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_model <= '0;
        else        ts_model <= ts_model + 16'd1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [27:0] mk(input logic f, input logic [2:0] s,
                                       input logic [7:0] r, input logic [15:0] t);
        return {f, s, r, t};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input logic [7:0] mask, output logic [15:0] tsm);
        step();
        err_src_i = mask;
        tsm = ts_model;
        step();
        err_src_i = '0;
        step();
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (!busy_o) quiet++;
            else quiet = 0;
            if (quiet >= 2) return;
        end
        fail_event("wait_idle timeout");
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (!hist_valid_o) break;
            hist_pop_i = 1'b1;
            step();
            hist_pop_i = 1'b0;
        end
    endtask

    task automatic pulse_ack();
        irq_ack_i = 1'b1;
        step();
        irq_ack_i = 1'b0;
    endtask

    task automatic pulse_clr();
        stat_clr_i = 1'b1;
        step();
        stat_clr_i = 1'b0;
    endtask

    // Recovery engine model: accepts a request, answers three cycles later.
    initial begin
        retry_ready_i = 1'b0;
        retry_done_i  = 1'b0;
        retry_ok_i    = 1'b0;
        forever begin
            step();
            retry_ready_i = 1'b0;
            retry_done_i  = 1'b0;
            retry_ok_i    = 1'b0;
            if (eng_wait > 0) begin
                eng_wait--;
                if (eng_wait == 0) begin
                    retry_done_i = 1'b1;
                    retry_ok_i   = (ok_q.size() > 0) ? ok_q.pop_front() : 1'b0;
                end
            end else if (retry_valid_o && !eng_hold) begin
                retry_ready_i = 1'b1;
                eng_wait = 3;
            end
        end
    end

    // Monitors: compare every DUT event against the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && err_clear_o != '0) begin
                if (exp_clr_q.size() == 0) fail_event("unexpected err_clear");
                else check("err_clear", err_clear_o, exp_clr_q.pop_front());
            end
            if (rst_n && retry_valid_o && retry_ready_i) begin
                if (exp_retry_q.size() == 0) fail_event("unexpected retry handshake");
                else check("retry_src", retry_src_o, exp_retry_q.pop_front());
            end
            if (rst_n && hist_pop_i && hist_valid_o) begin
                if (exp_hist_q.size() == 0) fail_event("unexpected hist entry");
                else check("hist_data", hist_data_o, exp_hist_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] tsm, tsm2;
        rst_n = 1'b0;
        err_src_i = '0; cfg_enable_i = 8'hFF; cfg_recov_i = '0; cfg_irq_en_i = 1'b1;
        cfg_threshold_i = '0; irq_ack_i = 1'b0; hist_pop_i = 1'b0; stat_clr_i = 1'b0;
        step(); step();
        check("rst irq", irq_o, 0);
        check("rst busy", busy_o, 0);
        check("rst hist_valid", hist_valid_o, 0);
        check("rst err_clear", err_clear_o, 0);
        check("rst retry_valid", retry_valid_o, 0);
        rst_n = 1'b1;
        step();
        check("rst count", err_count_o, 0);

        // Fatal path on src3 with exact latency.
        exp_clr_q.push_back(8'h08);
        fire(8'h08, tsm);
        exp_hist_q.push_back(mk(1'b1, 3'd3, 8'd0, tsm + 16'd2));
        step();
        check("fatal irq E+2", irq_o, 0);
        step();
        check("fatal irq E+3", irq_o, 1);
        step();
        check("fatal clear E+4", err_clear_o, 8'h08);
        step();
        check("fatal idle E+5", busy_o, 0);
        pulse_ack();
        check("irq ack", irq_o, 0);
        drain();
        check("count after fatal", err_count_o, 1);

        // Recoverable src1 succeeds first time.
        cfg_recov_i = 8'h02;
        ok_q.push_back(1'b1);
        exp_retry_q.push_back(3'd1);
        exp_clr_q.push_back(8'h02);
        fire(8'h02, tsm);
        exp_hist_q.push_back(mk(1'b0, 3'd1, 8'd1, tsm + 16'd2));
        wait_idle();
        check("retry ok no irq", irq_o, 0);
        drain();

        // Recoverable src4 fails every attempt.
        cfg_recov_i = 8'h12;
        for (int k = 0; k < 3; k++) begin
            ok_q.push_back(1'b0);
            exp_retry_q.push_back(3'd4);
        end
        exp_clr_q.push_back(8'h10);
        fire(8'h10, tsm);
        exp_hist_q.push_back(mk(1'b1, 3'd4, 8'd3, tsm + 16'd2));
        wait_idle();
        check("exhaust irq", irq_o, 1);
        pulse_ack();
        drain();

        // Priority src2 before src5; re-pulsed src5 coalesces.
        cfg_recov_i = '0;
        exp_clr_q.push_back(8'h04);
        exp_clr_q.push_back(8'h20);
        fire(8'h24, tsm);
        err_src_i = 8'h20;
        step();
        err_src_i = '0;
        exp_hist_q.push_back(mk(1'b1, 3'd2, 8'd0, tsm + 16'd2));
        exp_hist_q.push_back(mk(1'b1, 3'd5, 8'd0, tsm + 16'd7));
        wait_idle();
        check("coalesce count", err_count_o, 5);
        pulse_ack();
        drain();

        // Overflow: nine fatal events, no pops.
        cfg_irq_en_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            exp_clr_q.push_back(8'h01);
            fire(8'h01, tsm);
            if (k < 8) exp_hist_q.push_back(mk(1'b1, 3'd0, 8'd0, tsm + 16'd2));
            wait_idle();
        end
        check("ovf set", hist_ovf_o, 1);
        check("count 14", err_count_o, 14);
        check("irq disabled", irq_o, 0);
        pulse_clr();
        check("ovf cleared", hist_ovf_o, 0);
        check("count cleared", err_count_o, 0);

        // Push with simultaneous pop while full.
        exp_clr_q.push_back(8'h01);
        fire(8'h01, tsm);
        exp_hist_q.push_back(mk(1'b1, 3'd0, 8'd0, tsm + 16'd2));
        step();
        step();
        hist_pop_i = 1'b1;
        step();
        hist_pop_i = 1'b0;
        wait_idle();
        check("ovf push+pop", hist_ovf_o, 0);
        drain();
        check("fifo drained", hist_valid_o, 0);

        // Threshold of two.
        cfg_threshold_i = 16'd2;
        pulse_clr();
        exp_clr_q.push_back(8'h40);
        fire(8'h40, tsm);
        exp_hist_q.push_back(mk(1'b1, 3'd6, 8'd0, tsm + 16'd2));
        wait_idle();
        check("thresh below", thresh_hit_o, 0);
        exp_clr_q.push_back(8'h40);
        fire(8'h40, tsm2);
        exp_hist_q.push_back(mk(1'b1, 3'd6, 8'd0, tsm2 + 16'd2));
        wait_idle();
        check("thresh hit", thresh_hit_o, 1);
        pulse_clr();
        check("thresh cleared", thresh_hit_o, 0);
        check("count cleared 2", err_count_o, 0);
        drain();

        // Reset asserted while a retry request is outstanding.
        cfg_recov_i = 8'h80;
        eng_hold = 1'b1;
        fire(8'h80, tsm);
        step();
        check("retry pending", retry_valid_o, 1);
        check("retry src7", retry_src_o, 3'd7);
        rst_n = 1'b0;
        #1;
        check("async drop retry_valid", retry_valid_o, 0);
        check("async idle", busy_o, 0);
        step();
        rst_n = 1'b1;
        eng_hold = 1'b0;
        step(); step(); step();
        check("post-reset busy", busy_o, 0);
        check("post-reset hist", hist_valid_o, 0);

        check("hist queue empty", exp_hist_q.size(), 0);
        check("clr queue empty", exp_clr_q.size(), 0);
        check("retry queue empty", exp_retry_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
